// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_ctrl.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__clkdiv_ctrl
//
// Programmable clock divider and gating controller for the clkinv tree.
// Q is a registered, glitch-free divided clock. TICK pulses once per
// divided period. Start and stop happen only at period boundaries, so the
// downstream tree never sees a runt pulse. The one exception is RST, which
// aborts immediately.
//
// Divide ratio N = DIV + 1. The range is 1 .. 2**WIDTH.
// Q is high for ceil(N/2) cycles and then low for floor(N/2) cycles.
//
// Ports:
//   CLK     in   source clock; all state changes on the rising edge
//   RST     in   synchronous reset, active-high; has priority over all inputs
//   EN      in   run request (level). Must be CLK-synchronous unless the
//                synchronizer build is selected.
//   LOAD    in   capture DIV into the shadow register on this edge
//   DIV     in   [WIDTH-1:0] divide ratio minus one
//   Q       out  divided clock (flop output); drives clkinv input I
//   TICK    out  high during the last source cycle of each divided period
//   ACTIVE  out  high while the controller is not idle
//   VDD/VSS inout power pins; present only when USE_POWER_PINS is defined
//
// Build options:
//   GF180MCU_FD_SC_MCU7T5V0__CLKDIV_ENSYNC_EN
//       When this macro is defined, EN passes through a 2-flop synchronizer
//       (cleared by RST) before it reaches the FSM. Every EN-related latency
//       grows by two cycles. EN may then be driven asynchronously.
//   USE_POWER_PINS
//       When this macro is defined, the VDD and VSS inout ports are exposed.
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_ctrl #(
    parameter int WIDTH = 8
) (
`ifdef USE_POWER_PINS
    inout  wire              VDD,
    inout  wire              VSS,
`endif
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIV,
    output logic             Q,
    output logic             TICK,
    output logic             ACTIVE
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] ratio_reg, ratio_next;
    logic [WIDTH-1:0] shadow_reg, shadow_next;
    logic             q_reg, q_next;
    logic             tick_reg, tick_next;
    logic             active_reg, active_next;
    logic             boundary;
    logic             en_fsm;

    // -----------------------------------------------------------------------
    // EN path into the FSM
    // -----------------------------------------------------------------------
`ifdef GF180MCU_FD_SC_MCU7T5V0__CLKDIV_ENSYNC_EN
    localparam int SYNC_STAGES = 2;

    logic en_sync_reg [SYNC_STAGES];

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_en_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge CLK) begin
                    if (RST) begin
                        en_sync_reg[gi] <= 1'b0;
                    end else begin
                        en_sync_reg[gi] <= EN;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge CLK) begin
                    if (RST) begin
                        en_sync_reg[gi] <= 1'b0;
                    end else begin
                        en_sync_reg[gi] <= en_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign en_fsm = en_sync_reg[SYNC_STAGES-1];
`else
    assign en_fsm = EN;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // A LOAD on this edge bypasses straight into a ratio update made on
        // the same edge. As a result, a LOAD that coincides with a period
        // boundary (or with an IDLE cycle) governs the very next period.
        shadow_next = LOAD ? DIV : shadow_reg;
        boundary    = (cnt_reg == ratio_reg);
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        ratio_next  = ratio_reg;

        case (state_reg)
            IDLE: begin
                cnt_next   = '0;
                ratio_next = shadow_next;
                if (en_fsm) begin
                    state_next = RUN;
                end
            end
            RUN, DRAIN: begin
                // The ratio changes only at the wrap. A mid-period reload
                // therefore never reshapes the period in flight.
                if (boundary) begin
                    cnt_next   = '0;
                    ratio_next = shadow_next;
                end else begin
                    cnt_next   = cnt_reg + CNT_ONE;
                end

                if (en_fsm) begin
                    state_next = RUN;
                end else if (state_reg == DRAIN && boundary) begin
                    state_next = IDLE;
                end else begin
                    state_next = DRAIN;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // The outputs are computed from the next state, so each flop output
        // describes the cycle that the state registers are about to enter.
        // The high phase is cnt <= floor(ratio/2), which equals
        // cnt < ceil(N/2).
        active_next = (state_next != IDLE);
        q_next      = active_next && (cnt_next <= (ratio_next >> 1));
        tick_next   = active_next && (cnt_next == ratio_next);
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            ratio_reg  <= '0;
            shadow_reg <= '0;
            q_reg      <= 1'b0;
            tick_reg   <= 1'b0;
            active_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            ratio_reg  <= ratio_next;
            shadow_reg <= shadow_next;
            q_reg      <= q_next;
            tick_reg   <= tick_next;
            active_reg <= active_next;
        end
    end

    assign Q      = q_reg;
    assign TICK   = tick_reg;
    assign ACTIVE = active_reg;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for gf180mcu_fd_sc_mcu7t5v0__clkdiv_ctrl.
//
// The reference model tracks the divider in terms of period length N,
// position within the period, and a pending N. Directed patterns pin the
// model to hand-derived waveforms. A long randomized run is then checked
// cycle by cycle against the model.
// ---------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_ctrl;

    localparam int WIDTH = 8;

`ifdef GF180MCU_FD_SC_MCU7T5V0__CLKDIV_ENSYNC_EN
    localparam int EN_LAT = 2;
`else
    localparam int EN_LAT = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] div;
    logic             q;
    logic             tick;
    logic             active;

`ifdef USE_POWER_PINS
    wire vdd = 1'b1;
    wire vss = 1'b0;
`endif

    gf180mcu_fd_sc_mcu7t5v0__clkdiv_ctrl #(.WIDTH(WIDTH)) dut (
`ifdef USE_POWER_PINS
        .VDD    (vdd),
        .VSS    (vss),
`endif
        .CLK    (clk),
        .RST    (rst),
        .EN     (en),
        .LOAD   (load),
        .DIV    (div),
        .Q      (q),
        .TICK   (tick),
        .ACTIVE (active)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0b required=%0b", name, $time, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
        end else begin
            $display("ok   %s pattern=%b", name, act);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural reference model
    //   m_run  : the divider is producing periods
    //   m_stop : EN was low at the last edge while running, so the divider
    //            halts at the end of the current period unless EN returns
    //   m_len  : N of the current period
    //   m_pos  : 0 .. N-1 position inside it
    //   m_pend : N to be used for the next period
    // -----------------------------------------------------------------------
    bit       m_valid = 0;
    bit       m_run, m_stop;
    int       m_len, m_pos, m_pend;
    bit [1:0] en_pipe;

    always @(posedge clk) begin : model_upd
        int np;
        bit en_now;
`ifdef GF180MCU_FD_SC_MCU7T5V0__CLKDIV_ENSYNC_EN
        en_now  = en_pipe[1];
        en_pipe = {en_pipe[0], en};
`else
        en_now  = en;
`endif
        if (rst) begin
            m_valid = 1;
            m_run   = 0;
            m_stop  = 0;
            m_len   = 1;
            m_pos   = 0;
            m_pend  = 1;
            en_pipe = 2'b00;
        end else begin
            np = load ? int'(div) + 1 : m_pend;
            if (!m_run) begin
                m_len = np;
                m_pos = 0;
                if (en_now) begin
                    m_run  = 1;
                    m_stop = 0;
                end
            end else if (m_pos == m_len - 1) begin
                m_pos = 0;
                m_len = np;
                if (m_stop && !en_now) m_run = 0;
                else m_stop = !en_now;
            end else begin
                m_pos++;
                m_stop = !en_now;
            end
            m_pend = np;
        end
    end

    // Single compare process: every cycle after the first reset edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_q",      q,      m_run && (m_pos < (m_len + 1) / 2));
            chk("model_tick",   tick,   m_run && (m_pos == m_len - 1));
            chk("model_active", active, m_run);
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Captures n consecutive cycles, MSB first. Returns one cycle after the
    // last sample.
    task automatic capture(input int n, output logic [15:0] qv,
                           output logic [15:0] tv, output logic [15:0] av);
        qv = '0;
        tv = '0;
        av = '0;
        for (int i = 0; i < n; i++) begin
            qv = {qv[14:0], q};
            tv = {tv[14:0], tick};
            av = {av[14:0], active};
            @(negedge clk);
        end
    endtask

    // Resets, loads d in IDLE, raises EN, and returns at the first cycle
    // of running (cnt=0 visible).
    task automatic restart(input logic [WIDTH-1:0] d);
        rst  = 1'b1;
        en   = 1'b0;
        load = 1'b0;
        step(1);
        rst  = 1'b0;
        load = 1'b1;
        div  = d;
        step(1);
        load = 1'b0;
        en   = 1'b1;
        step(1 + EN_LAT);
    endtask

    logic [15:0] qv, tv, av;

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        load = 1'b1;
        div  = 8'd5;

        // Reset held for 3 cycles with every other input active.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_q",      q,      1'b0);
            chk("reset_tick",   tick,   1'b0);
            chk("reset_active", active, 1'b0);
        end
        rst  = 1'b0;
        load = 1'b0;
        step(1 + EN_LAT);
        chk("release_q",      q,      1'b1);
        chk("release_active", active, 1'b1);

        // Divide by 4.
        restart(8'd3);
        capture(8, qv, tv, av);
        chkv("div4_q",    qv, 16'b11001100);
        chkv("div4_tick", tv, 16'b00010001);

        // Divide by 5 (odd): the high phase is one cycle longer.
        restart(8'd4);
        capture(10, qv, tv, av);
        chkv("div5_q",    qv, 16'b1110011100);
        chkv("div5_tick", tv, 16'b0000100001);

        // Divide by 1.
        restart(8'd0);
        capture(6, qv, tv, av);
        chkv("div1_q",    qv, 16'b111111);
        chkv("div1_tick", tv, 16'b111111);

        // Aligned stop: drop EN while cnt=2 of a divide-by-8.
        restart(8'd7);
        step(2);
        en = 1'b0;
        step(1);
        capture(6, qv, tv, av);
        chkv("stop_q",      qv, 16'b100000);
        chkv("stop_tick",   tv, 16'b000010);
        chkv("stop_active", av, 16'b111110);

        // Re-raise EN during drain at cnt=5: no gap in counting.
        restart(8'd7);
        step(2);
        en = 1'b0;
        step(3);
        en = 1'b1;
        step(1);
        capture(10, qv, tv, av);
        chkv("resume_q",      qv, 16'b0011110000);
        chkv("resume_active", av, 16'b1111111111);

        // Mid-period reload: the current period stays 4, later periods are 2.
        restart(8'd3);
        step(1);
        load = 1'b1;
        div  = 8'd1;
        step(1);
        load = 1'b0;
        capture(6, qv, tv, av);
        chkv("reload_q",    qv, 16'b001010);
        chkv("reload_tick", tv, 16'b010101);

        // Reset mid-run aborts on the next edge.
        restart(8'd5);
        step(2);
        rst = 1'b1;
        step(1);
        chk("abort_q",      q,      1'b0);
        chk("abort_tick",   tick,   1'b0);
        chk("abort_active", active, 1'b0);
        rst = 1'b0;
        en  = 1'b0;

        // Randomized run, checked every cycle by the compare process.
        for (int c = 0; c < 4000; c++) begin
            rst  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) en = ~en;
            load = ($urandom_range(0, 7) == 0);
            div  = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 255))
                                               : WIDTH'($urandom_range(0, 6));
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__clkdiv_ctrl.md
Name: gf180mcu_fd_sc_mcu7t5v0__clkdiv_ctrl

Overview:
Synchronous programmable clock divider and gating controller that sits directly upstream of the clkinv clock-inverter cells.
- Produces a registered, glitch-free divided clock Q, which drives the clkinv tree input I.
- Also produces a one-cycle TICK pulse per divided period.
- Start/stop is period-aligned, so the downstream clock tree never sees a runt pulse.

Parameters:
WIDTH, 8, width of divide-ratio input DIV; divide ratio N = DIV+1, range 1..2^WIDTH.

Ports:
CLK    input   1      source clock; all state updates on rising edge
RST    input   1      synchronous reset, active-high
EN     input   1      run request; level-sensitive
LOAD   input   1      capture DIV into shadow register this cycle
DIV    input   WIDTH  divide ratio minus one
Q      output  1      divided clock, registered; feeds clkinv I
TICK   output  1      one-cycle pulse on last source cycle of each divided period
ACTIVE output  1      1 when state != IDLE
VDD, VSS  inout  1    present only under USE_POWER_PINS

Behaviour:
Clock and reset:
- One clock, CLK. RST is synchronous and active-high.
- RST=1 at a rising edge sets: state=IDLE, cnt=0, shadow=0, ratio=0 (N=1), Q=0, TICK=0, ACTIVE=0.
- RST has priority over EN and LOAD.
- RST asserted mid-period aborts immediately; Q=0 on the next edge. This is the only permitted non-aligned stop.

Ratio loading:
- LOAD=1 captures DIV into shadow on that edge.
- shadow is copied to the active ratio in IDLE every cycle, and in RUN/DRAIN only when cnt==ratio, i.e. at the period boundary.
- A mid-period LOAD never alters the current period.
- LOAD and a boundary on the same edge: the new DIV value is applied to the next period.

Counter:
- cnt is WIDTH bits and counts 0..ratio, then wraps to 0.
- Q is registered: Q=1 while cnt < ceil(N/2), else Q=0.
- Duty: N even gives 50%; N odd gives high one cycle longer than low.
- N=1 (DIV=0): Q stays 1 while RUN. TICK is 1 every cycle.

FSM states: IDLE, RUN, DRAIN.
- IDLE: Q=0, cnt=0. EN=1 -> RUN. First RUN cycle has cnt=0 and Q=1, so Q rises one cycle after EN is sampled high.
- RUN: count. EN=0 -> DRAIN. Counting continues unchanged.
- DRAIN: count. At cnt==ratio with EN=0 -> IDLE, and Q is 0 from the next cycle.
- DRAIN: EN=1 at any point -> RUN, with no break in counting.
- EN toggling within a period has no effect beyond the state change; Q is never truncated.

Outputs:
- TICK = (state!=IDLE && cnt==ratio), registered so that it coincides with Q's last low cycle (last high cycle when N=1).
- ACTIVE is registered and equals (next state != IDLE).
- All outputs are flop outputs. No combinational path from any input to any output.

Optional Feature:
Macro: GF180MCU_FD_SC_MCU7T5V0__CLKDIV_ENSYNC_EN
- Defined: EN passes through a 2-flop synchronizer, reset to 0 by RST, before reaching the FSM. All EN-related latencies increase by 2 cycles. EN may then be driven asynchronously.
- Undefined: EN is sampled directly and must be synchronous to CLK.
- Counter, Q, TICK and LOAD behaviour are identical in both builds.

Test Plan:
1. Reset: RST=1 for 3 cycles with EN=1, DIV=5, LOAD=1 -> Q=0, TICK=0, ACTIVE=0 throughout; one cycle after RST release, ACTIVE=1 and Q=1.
2. Divide-by-4: LOAD DIV=3 in IDLE, EN=1 -> Q pattern 1,1,0,0 repeating; TICK high on every 4th cycle, aligned with the second 0.
3. Odd and unity ratios: DIV=4 -> Q 1,1,1,0,0 repeating. DIV=0 -> Q constant 1 and TICK constant 1 while RUN.
4. Aligned stop: DIV=7 running, drop EN at cnt=2 -> Q completes 4 high and 4 low, TICK fires once, then IDLE with Q=0 and ACTIVE=0. Re-raise EN during DRAIN at cnt=5 -> counting continues with no gap.
5. Mid-period reload: running DIV=3, LOAD DIV=1 at cnt=1 -> current period stays 4 cycles; subsequent periods are 1,0 repeating.
6. Macro defined: EN rise -> Q first rises 3 cycles after EN is sampled (versus 1 cycle undefined). Reset mid-run -> Q=0 on the next edge in both builds.
